// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order completion buffer between the reservation
// stations and the register file. Allocates tags at dispatch, captures two
// ALU completions per cycle and retires up to two finished entries per cycle
// in program order.
// Optional macro ROB_BYPASS_EN: lookups also see the current cycle's
// completion ports (port 1 over port 0 over stored state).
module reorder_buffer #(
    parameter int DEPTH  = 32,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic [4:0]        alloc_rd,
    output logic [TAG_W-1:0]  alloc_tag,
    output logic              alloc_ack,
    output logic              full,
    output logic              empty,
    output logic [TAG_W:0]    count,
    input  logic              cmp_valid0,
    input  logic              cmp_valid1,
    input  logic [TAG_W-1:0]  cmp_tag0,
    input  logic [TAG_W-1:0]  cmp_tag1,
    input  logic [DATA_W-1:0] cmp_value0,
    input  logic [DATA_W-1:0] cmp_value1,
    input  logic [TAG_W-1:0]  lk_tag_a,
    input  logic [TAG_W-1:0]  lk_tag_b,
    output logic              lk_ready_a,
    output logic              lk_ready_b,
    output logic [DATA_W-1:0] lk_value_a,
    output logic [DATA_W-1:0] lk_value_b,
    output logic              cmt_valid0,
    output logic              cmt_valid1,
    output logic [4:0]        cmt_rd0,
    output logic [4:0]        cmt_rd1,
    output logic [DATA_W-1:0] cmt_value0,
    output logic [DATA_W-1:0] cmt_value1
);

    localparam int CW = TAG_W + 1;

    logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d;
    logic [4:0]        rd_q    [DEPTH];
    logic [4:0]        rd_d    [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d, head1;
    logic [CW-1:0]     count_q, count_d;
    logic              cmt0, cmt1;
    logic              cv0_q, cv0_d, cv1_q, cv1_d;
    logic [4:0]        crd0_q, crd0_d, crd1_q, crd1_d;
    logic [DATA_W-1:0] cval0_q, cval0_d, cval1_q, cval1_d;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign alloc_tag = tail_q;
    // Space freed by a same-cycle commit is not reusable until next cycle.
    assign alloc_ack = alloc_valid & ~full & ~flush & ~rst;

    assign head1 = head_q + TAG_W'(1);
    assign cmt0  = busy_q[head_q] & done_q[head_q];
    assign cmt1  = cmt0 & busy_q[head1] & done_q[head1];

    assign cmt_valid0 = cv0_q;
    assign cmt_valid1 = cv1_q;
    assign cmt_rd0    = crd0_q;
    assign cmt_rd1    = crd1_q;
    assign cmt_value0 = cval0_q;
    assign cmt_value1 = cval1_q;

    // Returns {ready, value} for one tag; value is zero unless ready.
    function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] t);
        logic [DATA_W:0] r;
        r = '0;
        if (busy_q[t]) begin
`ifdef ROB_BYPASS_EN
            if (cmp_valid1 && cmp_tag1 == t)      r = {1'b1, cmp_value1};
            else if (cmp_valid0 && cmp_tag0 == t) r = {1'b1, cmp_value0};
            else if (done_q[t])                   r = {1'b1, value_q[t]};
`else
            if (done_q[t]) r = {1'b1, value_q[t]};
`endif
        end
        return r;
    endfunction

    // Tag lookups for operand forwarding at dispatch.
    always_comb begin
        {lk_ready_a, lk_value_a} = lookup(lk_tag_a);
        {lk_ready_b, lk_value_b} = lookup(lk_tag_b);
    end

    // Next state: flush overrides allocation, completion and commit.
    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        rd_d    = rd_q;
        value_d = value_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        cv0_d   = 1'b0;
        cv1_d   = 1'b0;
        crd0_d  = '0;
        crd1_d  = '0;
        cval0_d = '0;
        cval1_d = '0;
        if (flush) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_ack) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = 1'b0;
                rd_d[tail_q]   = alloc_rd;
                tail_d         = tail_q + TAG_W'(1);
            end
            // Port 1 is applied last so it wins on a shared tag.
            if (cmp_valid0 && busy_q[cmp_tag0] && !(alloc_ack && cmp_tag0 == tail_q)) begin
                done_d[cmp_tag0]  = 1'b1;
                value_d[cmp_tag0] = cmp_value0;
            end
            if (cmp_valid1 && busy_q[cmp_tag1] && !(alloc_ack && cmp_tag1 == tail_q)) begin
                done_d[cmp_tag1]  = 1'b1;
                value_d[cmp_tag1] = cmp_value1;
            end
            if (cmt0) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                cv0_d          = 1'b1;
                crd0_d         = rd_q[head_q];
                cval0_d        = value_q[head_q];
            end
            if (cmt1) begin
                busy_d[head1] = 1'b0;
                done_d[head1] = 1'b0;
                cv1_d         = 1'b1;
                crd1_d        = rd_q[head1];
                cval1_d       = value_q[head1];
            end
            head_d  = head_q + TAG_W'({cmt1, cmt0 & ~cmt1});
            count_d = count_q + CW'(alloc_ack) - CW'(cmt0) - CW'(cmt1);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cv0_q   <= 1'b0;
            cv1_q   <= 1'b0;
            crd0_q  <= '0;
            crd1_q  <= '0;
            cval0_q <= '0;
            cval1_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            value_q <= value_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cv0_q   <= cv0_d;
            cv1_q   <= cv1_d;
            crd0_q  <= crd0_d;
            crd1_q  <= crd1_d;
            cval0_q <= cval0_d;
            cval1_q <= cval1_d;
        end
    end

endmodule
